// File: rtl/host.sv
// Host-side virtual-JTAG initiator for the Nios II debug slave.
// Ports: cmd_* in, rsp_* out, vs_* strobes, jtag_state_rti, tdi/tdo serial.
module host #(
  parameter int DR_WIDTH   = 38,
  parameter int IR_WIDTH   = 2,
  parameter int SHIFT_DIV  = 1,
  parameter int RTI_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic                busy,
  output logic [IR_WIDTH-1:0] vs_ir_in,
  output logic                vs_uir,
  output logic                vs_cdr,
  output logic                vs_sdr,
  output logic                vs_udr,
  output logic                jtag_state_rti,
  output logic                tdi,
  input  logic                tdo
);

  localparam int CW = $clog2(DR_WIDTH + 1);
  localparam int DW = $clog2(SHIFT_DIV + 1);
  localparam int RW = $clog2(RTI_CYCLES + 1);

  localparam logic [CW-1:0] BIT_LAST = CW'(DR_WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SHIFT_DIV - 1);
  localparam logic [RW-1:0] RTI_LAST = RW'(RTI_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RTI, S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       bit_q, bit_d;
  logic [DW-1:0]       div_q, div_d;
  logic [RW-1:0]       rti_q, rti_d;
  logic [DR_WIDTH-1:0] shreg_q, shreg_d;
  logic [DR_WIDTH-1:0] rsp_dr_q, rsp_dr_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic cmd_ready_q, cmd_ready_d;
  logic rsp_valid_q, rsp_valid_d;
  logic busy_q, busy_d;
  logic uir_q, uir_d;
  logic cdr_q, cdr_d;
  logic sdr_q, sdr_d;
  logic udr_q, udr_d;
  logic rti_st_q, rti_st_d;
  logic tdi_q, tdi_d;

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    div_d    = div_q;
    rti_d    = rti_q;
    shreg_d  = shreg_q;
    rsp_dr_d = rsp_dr_q;
    ir_d     = ir_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (cmd_valid && cmd_ready_q) begin
          ir_d    = cmd_ir;
          shreg_d = cmd_dr;
          bit_d   = '0;
          div_d   = '0;
          state_d = S_UIR;
        end
      end
      (state_q == S_UIR): state_d = S_CDR;
      (state_q == S_CDR): begin
        bit_d   = '0;
        div_d   = '0;
        state_d = S_SDR;
      end
      (state_q == S_SDR): begin
        // Shift only on the last divider cycle of each bit.
        if (div_q == DIV_LAST) begin
          shreg_d = {tdo, shreg_q[DR_WIDTH-1:1]};
          div_d   = '0;
          bit_d   = bit_q + CW'(1);
          if (bit_q == BIT_LAST) state_d = S_UDR;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      (state_q == S_UDR): begin
        rsp_dr_d = shreg_q;
        rti_d    = '0;
        state_d  = S_RTI;
      end
      (state_q == S_RTI): begin
        if (rti_q == RTI_LAST) state_d = S_RESP;
        else                   rti_d   = rti_q + RW'(1);
      end
      (state_q == S_RESP): begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered copies of what the next state implies.
  always_comb begin
    cmd_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
    busy_d      = (state_d != S_IDLE);
    uir_d       = (state_d == S_UIR);
    cdr_d       = (state_d == S_CDR);
    sdr_d       = (state_d == S_SDR) && (div_d == DIV_LAST);
    udr_d       = (state_d == S_UDR);
    rti_st_d    = (state_d == S_RTI);
    tdi_d       = (state_d == S_SDR) && shreg_d[0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      bit_q       <= '0;
      div_q       <= '0;
      rti_q       <= '0;
      shreg_q     <= '0;
      rsp_dr_q    <= '0;
      ir_q        <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      uir_q       <= 1'b0;
      cdr_q       <= 1'b0;
      sdr_q       <= 1'b0;
      udr_q       <= 1'b0;
      rti_st_q    <= 1'b0;
      tdi_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_q       <= bit_d;
      div_q       <= div_d;
      rti_q       <= rti_d;
      shreg_q     <= shreg_d;
      rsp_dr_q    <= rsp_dr_d;
      ir_q        <= ir_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
      uir_q       <= uir_d;
      cdr_q       <= cdr_d;
      sdr_q       <= sdr_d;
      udr_q       <= udr_d;
      rti_st_q    <= rti_st_d;
      tdi_q       <= tdi_d;
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_dr         = rsp_dr_q;
  assign busy           = busy_q;
  assign vs_ir_in       = ir_q;
  assign vs_uir         = uir_q;
  assign vs_cdr         = cdr_q;
  assign vs_sdr         = sdr_q;
  assign vs_udr         = udr_q;
  assign jtag_state_rti = rti_st_q;
  assign tdi            = tdi_q;

endmodule

// File: tb/tb_host.sv
// Testbench for host: default instance plus a SHIFT_DIV=3 instance,
// each looped back through a behavioural 38-bit slave shift register.
module tb_host;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Default instance
  logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy;
  logic [1:0]  cmd_ir, vs_ir_in;
  logic [37:0] cmd_dr, rsp_dr;
  logic        vs_uir, vs_cdr, vs_sdr, vs_udr, rti, tdi, tdo;

  // SHIFT_DIV=3 instance
  logic        cmd_valid2, cmd_ready2, rsp_valid2, rsp_ready2, busy2;
  logic [1:0]  cmd_ir2, vs_ir_in2;
  logic [37:0] cmd_dr2, rsp_dr2;
  logic        vs_uir2, vs_cdr2, vs_sdr2, vs_udr2, rti2, tdi2, tdo2;

  host u_dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_dr(cmd_dr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dr(rsp_dr),
    .busy(busy), .vs_ir_in(vs_ir_in),
    .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr),
    .jtag_state_rti(rti), .tdi(tdi), .tdo(tdo)
  );

  host #(.SHIFT_DIV(3)) u_div (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_ir(cmd_ir2), .cmd_dr(cmd_dr2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_dr(rsp_dr2),
    .busy(busy2), .vs_ir_in(vs_ir_in2),
    .vs_uir(vs_uir2), .vs_cdr(vs_cdr2), .vs_sdr(vs_sdr2), .vs_udr(vs_udr2),
    .jtag_state_rti(rti2), .tdi(tdi2), .tdo(tdo2)
  );

  // Slave models: tdo is bit 0 before the shift on a vs_sdr cycle.
  logic [37:0] slave, slave2, ld_val, ld_val2;
  logic        ld, ld2;
  always @(posedge clk) begin
    if (ld) slave <= ld_val;
    else if (vs_sdr) slave <= {tdi, slave[37:1]};
    if (ld2) slave2 <= ld_val2;
    else if (vs_sdr2) slave2 <= {tdi2, slave2[37:1]};
  end
  assign tdo  = slave[0];
  assign tdo2 = slave2[0];

  logic [1:0] last_ir;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [37:0] v);
    ld_val = v;
    ld = 1'b1;
    tick;
    ld = 1'b0;
  endtask

  // One command on the default instance; the expected response is the
  // slave's old content, and the slave ends up holding the command word.
  task automatic run_cmd(input logic [1:0] ir, input logic [37:0] dr,
                         input logic [37:0] pre, input int hold);
    int k, n_uir, n_cdr, n_sdr, n_udr, n_rti;
    int c_uir, c_cdr, c_sdr, c_udr, c_rti, oh_bad, busy_bad;
    logic [37:0] held;
    preload(pre);
    chk("ready_idle", 64'(cmd_ready), 64'(1));
    chk("ir_before_hs", 64'(vs_ir_in), 64'(last_ir));
    cmd_ir = ir;
    cmd_dr = dr;
    cmd_valid = 1'b1;
    rsp_ready = (hold == 0);
    tick;
    cmd_valid = 1'b0;
    last_ir = ir;
    chk("ir_after_hs", 64'(vs_ir_in), 64'(ir));
    n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0; n_rti = 0;
    c_uir = -1; c_cdr = -1; c_sdr = -1; c_udr = -1; c_rti = -1;
    oh_bad = 0; busy_bad = 0;
    k = 1;
    while (!rsp_valid && k < 200) begin
      if ($countones({vs_uir, vs_cdr, vs_sdr, vs_udr, rti}) > 1) oh_bad++;
      if (!busy || cmd_ready) busy_bad++;
      if (vs_uir) begin n_uir++; c_uir = k; end
      if (vs_cdr) begin n_cdr++; c_cdr = k; end
      if (vs_sdr) begin n_sdr++; if (c_sdr < 0) c_sdr = k; end
      if (vs_udr) begin n_udr++; c_udr = k; end
      if (rti) begin n_rti++; if (c_rti < 0) c_rti = k; end
      tick;
      k++;
    end
    chk("latency", 64'(k), 64'(44));
    chk("uir_cycle", 64'(c_uir), 64'(1));
    chk("cdr_cycle", 64'(c_cdr), 64'(2));
    chk("sdr_first", 64'(c_sdr), 64'(3));
    chk("sdr_count", 64'(n_sdr), 64'(38));
    chk("udr_cycle", 64'(c_udr), 64'(41));
    chk("rti_first", 64'(c_rti), 64'(42));
    chk("rti_count", 64'(n_rti), 64'(2));
    chk("single_pulses", 64'(n_uir + n_cdr + n_udr), 64'(3));
    chk("onehot", 64'(oh_bad), 64'(0));
    chk("busy_noready", 64'(busy_bad), 64'(0));
    chk("rsp_dr", 64'(rsp_dr), 64'(pre));
    chk("slave_after", 64'(slave), 64'(dr));
    held = rsp_dr;
    if (hold > 0) begin
      cmd_valid = 1'b1;
      cmd_dr = ~dr;
      repeat (hold) begin
        tick;
        chk("bp_rsp_valid", 64'(rsp_valid), 64'(1));
        chk("bp_rsp_stable", 64'(rsp_dr), 64'(held));
        chk("bp_cmd_ready", 64'(cmd_ready), 64'(0));
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    tick;
    chk("post_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("post_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("post_busy", 64'(busy), 64'(0));
  endtask

  initial begin
    int k, tdi_bad, sdr_bad;
    logic [63:0] r;
    logic [37:0] pre2;
    logic        e_tdi, e_sdr;
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_ir = '0; cmd_dr = '0; rsp_ready = 1'b1;
    cmd_valid2 = 1'b0; cmd_ir2 = '0; cmd_dr2 = '0; rsp_ready2 = 1'b1;
    ld = 1'b0; ld2 = 1'b0; ld_val = '0; ld_val2 = '0;
    last_ir = '0;
    tick;
    tick;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_dr", 64'(rsp_dr), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ir", 64'(vs_ir_in), 64'(0));
    chk("rst_strobes", 64'({vs_uir, vs_cdr, vs_sdr, vs_udr, rti, tdi}), 64'(0));
    reset = 1'b0;
    tick;
    chk("rel_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("rel_busy", 64'(busy), 64'(0));

    // Default loopback
    run_cmd(2'b10, 38'h2A_AAAA_AAAA, 38'h15_5555_5555, 0);

    // IR hold across two commands, then back-pressure and back-to-back
    run_cmd(2'b01, 38'h00_1234_5678, 38'h3F_0000_FFFF, 0);
    run_cmd(2'b11, 38'h3F_FFFF_FFFF, 38'h00_0000_0001, 10);
    run_cmd(2'b00, 38'h00_0000_0000, 38'h2A_5A5A_A5A5, 0);

    // Randomised commands
    for (int i = 0; i < 6; i++) begin
      logic [37:0] d, p;
      r = {$urandom, $urandom};
      d = r[37:0];
      r = {$urandom, $urandom};
      p = r[37:0];
      run_cmd(2'($urandom_range(0, 3)), d, p, int'($urandom_range(0, 3)));
    end

    // Reset in the 20th shift cycle
    preload(38'h11_2233_4455);
    cmd_ir = 2'b01;
    cmd_dr = 38'h22_3344_5566;
    cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
    repeat (21) tick;
    chk("mid_in_sdr", 64'(vs_sdr), 64'(1));
    reset = 1'b1;
    tick;
    chk("mid_strobes", 64'({vs_uir, vs_cdr, vs_sdr, vs_udr, rti}), 64'(0));
    chk("mid_busy", 64'(busy), 64'(0));
    chk("mid_rsp_dr", 64'(rsp_dr), 64'(0));
    chk("mid_rsp_valid", 64'(rsp_valid), 64'(0));
    reset = 1'b0;
    last_ir = '0;
    tick;
    r = {$urandom, $urandom};
    run_cmd(2'b10, 38'h0F_0F0F_0F0F, r[37:0], 2);

    // Divider instance, SHIFT_DIV=3
    r = {$urandom, $urandom};
    pre2 = r[37:0];
    ld_val2 = pre2;
    ld2 = 1'b1;
    tick;
    ld2 = 1'b0;
    cmd_ir2 = 2'b01;
    cmd_dr2 = 38'h1;
    cmd_valid2 = 1'b1;
    tick;
    cmd_valid2 = 1'b0;
    tdi_bad = 0;
    sdr_bad = 0;
    k = 1;
    while (!rsp_valid2 && k < 400) begin
      e_tdi = (k >= 3 && k <= 5);
      e_sdr = (k >= 3 && k <= 116 && (k % 3 == 2));
      if (tdi2 !== e_tdi) tdi_bad++;
      if (vs_sdr2 !== e_sdr) sdr_bad++;
      tick;
      k++;
    end
    chk("div_latency", 64'(k), 64'(120));
    chk("div_tdi", 64'(tdi_bad), 64'(0));
    chk("div_sdr", 64'(sdr_bad), 64'(0));
    chk("div_rsp_dr", 64'(rsp_dr2), 64'(pre2));
    chk("div_slave", 64'(slave2), 64'(1));
    tick;
    chk("div_idle", 64'(cmd_ready2), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
